// File: rtl/repeat_iogroup_bank.sv
// Wishbone-classic slave exposing N_CHAN repeated register groups: one RW control register
// and one sticky W1C status register per channel, plus bus error on unmapped channels.
module repeat_iogroup_bank #(
  parameter int unsigned       N_CHAN  = 2,
  parameter int unsigned       REG_W   = 32,
  parameter logic [REG_W-1:0]  CTL_RST = '0,
  parameter int unsigned       AW      = ((N_CHAN > 1) ? $clog2(N_CHAN) : 1) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [AW-1:0]           wb_adr_i,
  input  logic [3:0]              wb_sel_i,
  input  logic                    wb_we_i,
  input  logic [31:0]             wb_dat_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic                    wb_stall_o,
  output logic [31:0]             wb_dat_o,
  output logic [N_CHAN*REG_W-1:0] ctl_o,
  output logic [N_CHAN-1:0]       ctl_wr_o,
  input  logic [N_CHAN*REG_W-1:0] sts_i
);
  localparam int unsigned CW = AW - 1;

  logic                           en, rd_req, wr_req;
  logic                           rd_hit, wr_hit;
  logic [CW-1:0]                  rd_chan, wr_chan;
  logic [REG_W-1:0]               rd_val, lane_mask;
  logic [N_CHAN-1:0][REG_W-1:0]   clr;

  logic                           rip_q, rip_d, wip_q, wip_d;
  logic                           rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic                           wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic [31:0]                    dat_q, dat_d;
  logic                           wreq_q, wreq_d;
  logic [AW-1:0]                  wadr_q, wadr_d;
  logic [REG_W-1:0]               wdat_q, wdat_d;
  logic [3:0]                     wsel_q, wsel_d;
  logic [N_CHAN-1:0][REG_W-1:0]   ctl_q, ctl_d, sts_q, sts_d;
  logic [N_CHAN-1:0]              ctl_wr_q, ctl_wr_d;

  logic unused_dat, unused_sel;
  assign unused_dat = ^wb_dat_i;
  assign unused_sel = ^wsel_q;

  // Read path: decoded straight off the live bus address, answered one cycle later.
  always_comb begin
    en      = wb_cyc_i & wb_stb_i;
    rd_req  = en & ~wb_we_i & ~rip_q;
    wr_req  = en & wb_we_i & ~wip_q;
    rd_chan = wb_adr_i[AW-1:1];
    rd_hit  = 1'b0;
    rd_val  = '0;
    for (int c = 0; c < int'(N_CHAN); c++) begin
      if (rd_chan == CW'(c)) begin
        rd_hit = 1'b1;
        rd_val = wb_adr_i[0] ? sts_q[c] : ctl_q[c];
      end
    end
    rd_ack_d = rd_req & rd_hit;
    rd_err_d = rd_req & ~rd_hit;
    dat_d    = (rd_req && rd_hit) ? 32'(rd_val) : 32'h0;
    rip_d    = rd_req | (rip_q & ~(rd_ack_q | rd_err_q));
    wip_d    = wr_req | (wip_q & ~(wr_ack_q | wr_err_q));
    wreq_d   = wr_req;
    wadr_d   = wb_adr_i;
    wdat_d   = wb_dat_i[REG_W-1:0];
    wsel_d   = wb_sel_i;
  end

  // Write path: works only from the d0 registers so a following read cannot disturb it.
  always_comb begin
    wr_chan  = wadr_q[AW-1:1];
    wr_hit   = 1'b0;
    ctl_d    = ctl_q;
    ctl_wr_d = '0;
    clr      = '0;
    for (int i = 0; i < int'(REG_W); i++) begin
      lane_mask[i] = wsel_q[i/8];
    end
    for (int c = 0; c < int'(N_CHAN); c++) begin
      if (wreq_q && (wr_chan == CW'(c))) begin
        wr_hit = 1'b1;
        if (!wadr_q[0]) begin
          ctl_d[c]    = (ctl_q[c] & ~lane_mask) | (wdat_q & lane_mask);
          ctl_wr_d[c] = 1'b1;
        end else begin
          clr[c] = wdat_q & lane_mask;
        end
      end
      // New events are OR'd in after the clear so a coincident set survives.
      sts_d[c] = (sts_q[c] & ~clr[c]) | sts_i[c*REG_W +: REG_W];
    end
    wr_ack_d = wreq_q & wr_hit;
    wr_err_d = wreq_q & ~wr_hit;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rip_q    <= 1'b0;
      wip_q    <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      dat_q    <= '0;
      wreq_q   <= 1'b0;
      wadr_q   <= '0;
      wdat_q   <= '0;
      wsel_q   <= '0;
      ctl_q    <= {N_CHAN{CTL_RST}};
      sts_q    <= '0;
      ctl_wr_q <= '0;
    end else begin
      rip_q    <= rip_d;
      wip_q    <= wip_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      dat_q    <= dat_d;
      wreq_q   <= wreq_d;
      wadr_q   <= wadr_d;
      wdat_q   <= wdat_d;
      wsel_q   <= wsel_d;
      ctl_q    <= ctl_d;
      sts_q    <= sts_d;
      ctl_wr_q <= ctl_wr_d;
    end
  end

  assign wb_ack_o   = rd_ack_q | wr_ack_q;
  assign wb_err_o   = rd_err_q | wr_err_q;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = en & ~(wb_ack_o | wb_err_o);
  assign wb_dat_o   = dat_q;
  assign ctl_o      = ctl_q;
  assign ctl_wr_o   = ctl_wr_q;

endmodule

// File: tb/tb_repeat_iogroup_bank.sv
// Bench for repeat_iogroup_bank: a 4-channel and a 3-channel instance (REG_W=16, CTL_RST=0xA5)
// driven from a vector table with a response scoreboard, plus hand-timed corner sequences.
module tb_repeat_iogroup_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cyc;
  logic        stb, we;
  logic [2:0]  adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [1:0]  ack, err, rty, stall;
  logic [31:0] rdat_a, rdat_b;
  logic [63:0] ctl_a, sts_a;
  logic [47:0] ctl_b, sts_b;
  logic [3:0]  ctl_wr_a;
  logic [2:0]  ctl_wr_b;

  repeat_iogroup_bank #(.N_CHAN(4), .REG_W(16), .CTL_RST(16'h00A5)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
    .wb_rty_o(rty[0]), .wb_stall_o(stall[0]), .wb_dat_o(rdat_a), .ctl_o(ctl_a),
    .ctl_wr_o(ctl_wr_a), .sts_i(sts_a)
  );

  repeat_iogroup_bank #(.N_CHAN(3), .REG_W(16), .CTL_RST(16'h00A5)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
    .wb_rty_o(rty[1]), .wb_stall_o(stall[1]), .wb_dat_o(rdat_b), .ctl_o(ctl_b),
    .ctl_wr_o(ctl_wr_b), .sts_i(sts_b)
  );

  typedef struct {
    int          tgt;
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        eack;
    logic        eerr;
    logic [31:0] edat;
  } vec_t;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          lat;
    logic        rd;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cnt[2];
  int   resp_cnt[2];
  int   both_cnt = 0;
  int   pulse_a[4];
  int   pulse_b = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (ack[i] | err[i]) resp_cnt[i]++;
    if ((ack[0] & err[0]) | (ack[1] & err[1]) | (|rty)) both_cnt++;
    for (int c = 0; c < 4; c++) if (ctl_wr_a[c]) pulse_a[c]++;
    if (|ctl_wr_b) pulse_b++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Issue one classic transfer; the expectation is queued now and retired on ack/err.
  task automatic bus(input string nm, input int t, input logic w, input logic [2:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic eack,
                     input logic eerr, input logic [31:0] edat);
    exp_t e;
    logic got;
    int   n;
    e = '{ack: eack, err: eerr, dat: edat, lat: (w ? 2 : 1), rd: ~w};
    sbq.push_back(e);
    @(posedge clk); #1;
    cyc = 2'b01 << t; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    req_cnt[t]++;
    got = 1'b0;
    n   = 0;
    while (!got && n < 6) begin
      @(negedge clk);
      if (ack[t] | err[t]) got = 1'b1;
      else n++;
    end
    e = sbq.pop_front();
    check({nm, "_resp"}, 64'(got), 64'd1);
    if (got) begin
      check({nm, "_lat"}, 64'(n), 64'(e.lat));
      check({nm, "_ack"}, 64'(ack[t]), 64'(e.ack));
      check({nm, "_err"}, 64'(err[t]), 64'(e.err));
      if (e.rd) check({nm, "_dat"}, 64'(t != 0 ? rdat_b : rdat_a), 64'(e.dat));
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cyc = 2'b00; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; cyc = '0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; wdat = '0;
    sts_a = '0; sts_b = '0;

    for (int c = 0; c < 4; c++)
      tbl.push_back('{0, 1'b0, 3'(c * 2), 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_00A5});
    for (int c = 0; c < 4; c++)
      tbl.push_back('{0, 1'b0, 3'(c * 2 + 1), 32'h0, 4'h0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 3'b100, 32'h1234_5678, 4'b0001, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 3'b100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_0078});
    tbl.push_back('{0, 1'b0, 3'b010, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_00A5});
    tbl.push_back('{0, 1'b0, 3'b110, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_00A5});
    tbl.push_back('{0, 1'b1, 3'b000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 3'b000, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_FFFF});
    tbl.push_back('{0, 1'b1, 3'b110, 32'h0000_FFFF, 4'b0000, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 3'b110, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_00A5});
    tbl.push_back('{1, 1'b0, 3'b110, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{1, 1'b1, 3'b110, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{1, 1'b0, 3'b111, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{1, 1'b1, 3'b100, 32'h0000_BEEF, 4'b0011, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b0, 3'b100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_BEEF});
    tbl.push_back('{1, 1'b0, 3'b000, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_00A5});
    tbl.push_back('{1, 1'b0, 3'b011, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0});

    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_dat", 64'(rdat_a), 64'd0);
    check("rst_ctl_a", ctl_a, {4{16'h00A5}});
    check("rst_ctl_wr", 64'({ctl_wr_b, ctl_wr_a}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      bus($sformatf("v%0d", i), tbl[i].tgt, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s,
          tbl[i].eack, tbl[i].eerr, tbl[i].edat);
    idle();
    check("pulse_a0", 64'(pulse_a[0]), 64'd1);
    check("pulse_a1", 64'(pulse_a[1]), 64'd0);
    check("pulse_a2", 64'(pulse_a[2]), 64'd1);
    check("pulse_a3", 64'(pulse_a[3]), 64'd1);
    check("pulse_b", 64'(pulse_b), 64'd1);
    check("ctl_a_tbl", ctl_a, {16'h00A5, 16'h0078, 16'h00A5, 16'hFFFF});
    check("ctl_b_tbl", 64'(ctl_b), 64'({16'hBEEF, 16'h00A5, 16'h00A5}));

    // Control update and strobe land exactly two cycles after the request.
    @(posedge clk); #1;
    cyc = 2'b01; stb = 1'b1; we = 1'b1; adr = 3'b010; wdat = 32'h0000_1234; sel = 4'b0011;
    req_cnt[0]++;
    @(negedge clk);
    @(negedge clk);
    check("h1_ctl_t1", 64'(ctl_a[31:16]), 64'h00A5);
    check("h1_ack_t1", 64'(ack[0]), 64'd0);
    check("h1_stall_t1", 64'(stall[0]), 64'd1);
    @(negedge clk);
    check("h1_ctl_t2", 64'(ctl_a[31:16]), 64'h1234);
    check("h1_ack_t2", 64'(ack[0]), 64'd1);
    check("h1_stall_t2", 64'(stall[0]), 64'd0);
    check("h1_wr_t2", 64'(ctl_wr_a), 64'b0010);
    idle();
    @(negedge clk);
    check("h1_ack_drop", 64'(ack[0]), 64'd0);
    check("h1_wr_drop", 64'(ctl_wr_a), 64'd0);

    // Sticky status with W1C and set-wins on channel 1 bit 3.
    @(posedge clk); #1 sts_a[19] = 1'b1;
    @(posedge clk); #1 sts_a[19] = 1'b0;
    bus("s_rd0", 0, 1'b0, 3'b011, 32'h0, 4'h0, 1'b1, 1'b0, 32'h8);
    bus("s_rd_ch0", 0, 1'b0, 3'b001, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    sts_a[19] = 1'b1;
    bus("s_wr_hold", 0, 1'b1, 3'b011, 32'h8, 4'b1111, 1'b1, 1'b0, 32'h0);
    bus("s_rd1", 0, 1'b0, 3'b011, 32'h0, 4'h0, 1'b1, 1'b0, 32'h8);
    sts_a[19] = 1'b0;
    bus("s_wr_lane", 0, 1'b1, 3'b011, 32'h8, 4'b0010, 1'b1, 1'b0, 32'h0);
    bus("s_rd2", 0, 1'b0, 3'b011, 32'h0, 4'h0, 1'b1, 1'b0, 32'h8);
    bus("s_wr_clr", 0, 1'b1, 3'b011, 32'h8, 4'b0001, 1'b1, 1'b0, 32'h0);
    bus("s_rd3", 0, 1'b0, 3'b011, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    idle();

    // Reset asserted in the cycle after a write request: transfer is dropped silently.
    @(posedge clk); #1;
    cyc = 2'b01; stb = 1'b1; we = 1'b1; adr = 3'b100; wdat = 32'h0000_5555; sel = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b0; cyc = 2'b00; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | ack[0] | err[0];
    end
    check("rst_mid_noresp", 64'(seen), 64'd0);
    check("rst_mid_ctl_a", ctl_a, {4{16'h00A5}});
    check("rst_mid_ctl_b", 64'(ctl_b), 64'({3{16'h00A5}}));
    @(posedge clk); #1 rst_n = 1'b1;
    bus("post_rst_rd", 0, 1'b0, 3'b100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_00A5);
    idle();
    repeat (2) @(negedge clk);

    check("resp_count_a", 64'(resp_cnt[0]), 64'(req_cnt[0]));
    check("resp_count_b", 64'(resp_cnt[1]), 64'(req_cnt[1]));
    check("ack_err_overlap", 64'(both_cnt), 64'd0);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/repeat_iogroup_bank.md
Name: repeat_iogroup_bank

Overview:
Parametrised Wishbone-classic slave providing N_CHAN repeated register groups. Each group has one RW control register, driven out as a flat vector, and one sticky W1C status register fed by per-channel event inputs. It is the generalised successor of the fixed two-entry repeated iogroup. It adds configurable channel count, register width and reset value, byte-lane writes, write-strobe outputs, sticky status and bus error on unmapped addresses.

Parameters:
N_CHAN, 2, number of channel groups (1..16)
REG_W, 32, implemented bits per register (1..32); upper bus bits read 0
CTL_RST, 0, reset value of every control register (REG_W bits)
AW, derived, = max(1,ceil(log2(N_CHAN)))+1, word-address width

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_n_i  in  1  reset, asynchronous, active-low
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_adr_i  in  AW  word address = byte address bits [AW+1:2]
wb_sel_i  in  4  byte-lane select
wb_we_i  in  1  write enable
wb_dat_i  in  32  write data
wb_ack_o  out  1  transfer acknowledge
wb_err_o  out  1  error (unmapped channel)
wb_rty_o  out  1  tied 0
wb_stall_o  out  1  stall
wb_dat_o  out  32  read data (registered)
ctl_o  out  N_CHAN*REG_W  control registers, channel c at bits [c*REG_W +: REG_W]
ctl_wr_o  out  N_CHAN  one-cycle pulse when channel c control register is written
sts_i  in  N_CHAN*REG_W  status event bits, level-sampled every cycle

Behaviour:
- Address map: word address = {chan, sel}. sel=0: control (RW). sel=1: status (R, W1C). chan >= N_CHAN is unmapped.
- Reset (async assert, sync release): ctl_o=CTL_RST, status=0, ctl_wr_o=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, rip/wip=0, pipeline regs=0. Reset mid-transaction drops the transfer; no ack/err is issued for it.
- Request qualification: en = cyc&stb. rd_req = en&~we&~rip. wr_req = en&we&~wip. rip/wip set on req, cleared on own ack/err. Exactly one ack or err per request.
- wb_stall_o = en & ~(ack|err). wb_rty_o = 0.
- Read, request in cycle T:
  - Decode is combinational on wb_adr_i. Data and ack/err are registered, so the response appears in T+1.
  - Control read: ctl zero-extended. Status read: sticky value zero-extended. Unmapped read: err=1, ack=0, dat=0.
- Write, request in cycle T:
  - req/adr/dat/sel are registered in T+1 (d0 stage) and decoded.
  - Register update and ack/err are registered, so both are visible in T+2.
  - Control write: byte lane b (bits 8b+7:8b, clipped to REG_W) is updated only when sel[b]=1. ctl_wr_o[c] pulses in T+2 even if sel=0000.
  - Status write: bits written 1 clear, bits written 0 unchanged. Byte lanes are honoured.
  - Unmapped write: err in T+2, no state change.
- Sticky status: each cycle sts_reg |= sts_i bits. If a set and a W1C clear hit the same bit in the same cycle, set wins (bit stays 1).
- Simultaneous read and write are impossible on classic WB. The independent rd/wr paths still must not corrupt each other if the master issues back-to-back read-after-write: the read decode uses current wb_adr_i, the write path uses d0 regs.
- Only one of ack/err is high in any cycle. Each is high for exactly one cycle per request.
- No combinational path from wb inputs to wb outputs except wb_stall_o.

Test Plan:
- Reset then read all: N_CHAN=4, REG_W=16, CTL_RST=0x00A5. Read ctl ch0..3 -> 0x000000A5 each, ack 1 cycle after stb. Status reads -> 0. ctl_wr_o=0.
- Byte-lane write: write ch2 ctl dat=0x12345678 sel=0001 -> ctl ch2 = 0x0078 visible 2 cycles after request. ctl_wr_o[2] pulses once. Other channels unchanged. Readback 0x00000078.
- Sticky/W1C: pulse sts_i ch1 bit3 for 1 cycle -> status read 0x8. Write 0x8 to ch1 status while holding bit3 high -> reads 0x8 (set wins). Release, write 0x8 -> reads 0.
- Unmapped: N_CHAN=3. Read and write chan=3 -> wb_err_o one cycle, at T+1 for the read and T+2 for the write. ack=0. No ctl/status change. ctl_wr_o=0.
- Back-to-back: write ch0 ctl 0xFFFF, then read ch0 immediately after ack -> 0x0000FFFF (REG_W=16 masks upper bits).
- Reset mid-write: assert rst_n_i in T+1 of a write -> no ack/err. ctl returns to CTL_RST. After release, the next read completes normally.
